// File: rtl/matmul_sequencer.sv
// Sequences a dense C = A x B pass one output element at a time: N operand reads,
// a LAT-cycle drain for the last products, then a held write of the 64-bit result.
module matmul_sequencer #(
    parameter int MAX_N = 64,
    parameter int AW    = 6,
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   n_cfg,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          a_rd_en,
    output logic          b_rd_en,
    output logic [AW-1:0] a_row,
    output logic [AW-1:0] a_col,
    output logic [AW-1:0] b_row,
    output logic [AW-1:0] b_col,
    input  logic [63:0]   a_data,
    input  logic [63:0]   b_data,
    output logic          c_wr_en,
    input  logic          c_wr_ready,
    output logic [AW-1:0] c_row,
    output logic [AW-1:0] c_col,
    output logic [63:0]   c_data
);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [AW:0]   n_q;
    logic [AW-1:0] i_q, j_q, k_q;
    logic [DW-1:0] d_q;
    logic [63:0]   acc;
    logic [LAT:1]  vld_pipe;
    logic          rd_en, cfg_ok, last_i, last_j, last_k, last_d, wr_hs, kill;

    assign rd_en   = (state == S_READ);
    assign busy    = (state != S_IDLE);
    assign cfg_ok  = (n_cfg != '0) && (n_cfg <= (AW+1)'(MAX_N));
    assign last_i  = ({1'b0, i_q} == n_q - 1'b1);
    assign last_j  = ({1'b0, j_q} == n_q - 1'b1);
    assign last_k  = ({1'b0, k_q} == n_q - 1'b1);
    assign last_d  = (d_q == DW'(LAT - 1));
    assign wr_hs   = (state == S_WRITE) && c_wr_ready;
    assign kill    = abort && busy;

    assign a_rd_en = rd_en;
    assign b_rd_en = rd_en;
    assign a_row   = i_q;
    assign a_col   = k_q;
    assign b_row   = k_q;
    assign b_col   = j_q;
    assign c_row   = i_q;
    assign c_col   = j_q;
    assign c_data  = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && cfg_ok) state_nxt = S_READ;
            S_READ:  if (last_k) state_nxt = S_DRAIN;
            S_DRAIN: if (last_d) state_nxt = S_WRITE;
            S_WRITE: if (c_wr_ready) state_nxt = (last_i && last_j) ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
        // abort only matters once a pass is running; in IDLE start wins
        if (kill) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            d_q      <= '0;
            acc      <= '0;
            vld_pipe <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            c_wr_en  <= 1'b0;
        end else begin
            state   <= state_nxt;
            c_wr_en <= (state_nxt == S_WRITE);
            done    <= wr_hs && last_i && last_j && !abort;
            cfg_err <= (state == S_IDLE) && start && !cfg_ok;

            // in-flight operand data is dropped on abort
            if (kill) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= rd_en;
                for (int s = 2; s <= LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
            end

            if (state_nxt == S_READ && state != S_READ)
                acc <= '0;
            else if (vld_pipe[LAT])
                acc <= acc + a_data * b_data;

            case (state)
                S_IDLE: begin
                    if (start && cfg_ok) begin
                        n_q <= n_cfg;
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                    end
                end
                S_READ: begin
                    k_q <= last_k ? '0 : k_q + 1'b1;
                    d_q <= '0;
                end
                S_DRAIN: d_q <= d_q + 1'b1;
                S_WRITE: begin
                    if (c_wr_ready) begin
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: operand memories with LAT-cycle read latency,
// a write scoreboard, and immediate-assertion checks at each step.
module tb_matmul_sequencer;
    localparam int MAX_N = 64;
    localparam int AW    = 6;
    localparam int LAT   = 2;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, c_wr_ready = 1'b1;
    logic [AW:0]   n_cfg = '0;
    logic          busy, done, cfg_err, a_rd_en, b_rd_en, c_wr_en;
    logic [AW-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
    logic [63:0]   a_data, b_data, c_data;

    matmul_sequencer #(.MAX_N(MAX_N), .AW(AW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_cfg(n_cfg), .abort(abort),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
        .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
        .a_data(a_data), .b_data(b_data),
        .c_wr_en(c_wr_en), .c_wr_ready(c_wr_ready),
        .c_row(c_row), .c_col(c_col), .c_data(c_data)
    );

    always #5 clk = ~clk;

    logic [63:0] A [MAX_N][MAX_N];
    logic [63:0] B [MAX_N][MAX_N];
    logic [63:0] ap [LAT:1];
    logic [63:0] bp [LAT:1];

    // operand memories: data shows up exactly LAT cycles after the read cycle
    always @(posedge clk) begin
        ap[1] <= A[a_row][a_col];
        bp[1] <= B[b_row][b_col];
        for (int s = 2; s <= LAT; s++) begin
            ap[s] <= ap[s-1];
            bp[s] <= bp[s-1];
        end
    end
    assign a_data = ap[LAT];
    assign b_data = bp[LAT];

    int cyc = 0;
    int rd_cnt = 0;
    int pair_bad = 0;
    int wr_row[$], wr_col[$], wr_cyc[$];
    logic [63:0] wr_data[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (a_rd_en) rd_cnt++;
            if (a_rd_en !== b_rd_en) pair_bad++;
            if (c_wr_en && c_wr_ready) begin
                wr_row.push_back(int'(c_row));
                wr_col.push_back(int'(c_col));
                wr_data.push_back(c_data);
                wr_cyc.push_back(cyc);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int n, output int s);
        @(negedge clk);
        start = 1'b1;
        n_cfg = (AW+1)'(n);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int s, input int budget, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) begin
                lat = cyc - s;
                break;
            end
        end
    endtask

    function automatic logic [63:0] ref_c(input int n, input int i, input int j);
        logic [63:0] acc;
        acc = '0;
        for (int k = 0; k < n; k++) acc = acc + A[i][k] * B[k][j];
        return acc;
    endfunction

    task automatic check_pass(input int n, input int base);
        chk("wr_count", wr_data.size(), base + n*n);
        for (int e = 0; e < n*n; e++) begin
            if (base + e < wr_data.size()) begin
                chk("wr_row", wr_row[base+e], e / n);
                chk("wr_col", wr_col[base+e], e % n);
                chk("wr_data", wr_data[base+e], ref_c(n, e / n, e % n));
            end
        end
    endtask

    task automatic quiet_window(input int cycles, input string tag);
        int seen_wr, seen_done;
        seen_wr = 0;
        seen_done = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c_wr_en) seen_wr++;
            if (done) seen_done++;
        end
        chk({tag, "_no_wr"}, seen_wr, 0);
        chk({tag, "_no_done"}, seen_done, 0);
    endtask

    initial begin
        int s, lat, base, rd0, w;
        logic [63:0] hold_d;
        int hold_r, hold_c, stall_bad;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("rst_c_wr_en", c_wr_en, 0);
        chk("rst_idx", {a_row, a_col, b_row, b_col, c_row, c_col}, 0);
        chk("rst_c_data", c_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // N=1: 3*5
        A[0][0] = 64'd3;
        B[0][0] = 64'd5;
        base = wr_data.size();
        kick(1, s);
        chk("n1_busy", busy, 1);
        chk("n1_rd_en", a_rd_en, 1);
        wait_done(s, 50, lat);
        chk("n1_latency", lat, 5);
        chk("n1_wr_cycle", (wr_cyc.size() > base) ? wr_cyc[base] - s : -1, 4);
        chk("n1_data", (wr_data.size() > base) ? wr_data[base] : 64'hdead, 64'd15);
        @(negedge clk);
        chk("n1_done_single", done, 0);
        chk("n1_idle", busy, 0);

        // N=2 hand values; a start mid-pass with another N must be ignored
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
        base = wr_data.size();
        kick(2, s);
        start = 1'b1;
        n_cfg = 7'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s, 100, lat);
        chk("n2_latency", lat, 21);
        chk("n2_count", wr_data.size() - base, 4);
        if (wr_data.size() >= base + 4) begin
            chk("n2_c00", wr_data[base], 64'd19);
            chk("n2_c01", wr_data[base+1], 64'd22);
            chk("n2_c10", wr_data[base+2], 64'd43);
            chk("n2_c11", wr_data[base+3], 64'd50);
            chk("n2_order", {wr_row[base+1], wr_col[base+1], wr_row[base+2], wr_col[base+2]},
                {32'd0, 32'd1, 32'd1, 32'd0});
        end

        // modulo-2^64 wrap: (2^63+1)^2 = 1, and sums of 2^126 vanish
        A[0][0] = 64'h8000_0000_0000_0001;
        B[0][0] = 64'h8000_0000_0000_0001;
        base = wr_data.size();
        kick(1, s);
        wait_done(s, 50, lat);
        chk("wrap1_data", (wr_data.size() > base) ? wr_data[base] : 64'hdead, 64'd1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                A[i][j] = 64'h8000_0000_0000_0000;
                B[i][j] = 64'h8000_0000_0000_0000;
            end
        base = wr_data.size();
        kick(4, s);
        wait_done(s, 200, lat);
        chk("wrap4_latency", lat, 4*4*7 + 1);
        chk("wrap4_count", wr_data.size() - base, 16);
        w = 0;
        for (int e = base; e < wr_data.size(); e++) if (wr_data[e] !== 64'd0) w++;
        chk("wrap4_all_zero", w, 0);

        // write back-pressure: 3 stalled cycles on the first N=2 write
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
        c_wr_ready = 1'b0;
        base = wr_data.size();
        kick(2, s);
        w = 0;
        while (!c_wr_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stall_wr_seen", c_wr_en, 1);
        hold_d = c_data;
        hold_r = int'(c_row);
        hold_c = int'(c_col);
        chk("stall_first_data", hold_d, 64'd19);
        stall_bad = 0;
        rd0 = rd_cnt;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!c_wr_en || c_data !== hold_d || int'(c_row) != hold_r ||
                int'(c_col) != hold_c || a_rd_en) stall_bad++;
        end
        c_wr_ready = 1'b1;
        chk("stall_hold", stall_bad, 0);
        chk("stall_no_rd", rd_cnt - rd0, 0);
        wait_done(s, 100, lat);
        chk("stall_latency", lat, 21 + 3);
        check_pass(2, base);

        // illegal sizes
        rd0 = rd_cnt;
        kick(0, s);
        chk("cfg0_err", cfg_err, 1);
        chk("cfg0_busy", busy, 0);
        @(negedge clk);
        chk("cfg0_err_pulse", cfg_err, 0);
        kick(65, s);
        chk("cfg65_err", cfg_err, 1);
        chk("cfg65_busy", busy, 0);
        @(negedge clk);
        chk("cfg65_busy_after", busy, 0);
        chk("cfg_no_reads", rd_cnt - rd0, 0);

        // abort during DRAIN
        base = wr_data.size();
        rd0 = rd_cnt;
        kick(2, s);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        quiet_window(12, "abort");
        chk("abort_reads", rd_cnt - rd0, 2);
        chk("abort_no_write", wr_data.size() - base, 0);

        // reset during READ
        kick(2, s);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", a_rd_en, 0);
        chk("midrst_idx", {a_col, c_row, c_col}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", busy, 0);
        quiet_window(10, "midrst");
        chk("midrst_no_write", wr_data.size() - base, 0);

        // fresh N=3 pass after the cancellations
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                A[i][j] = 64'(i*3 + j + 1);
                B[i][j] = 64'(i*5 + j + 2);
            end
        base = wr_data.size();
        kick(3, s);
        wait_done(s, 200, lat);
        chk("n3_latency", lat, 9*6 + 1);
        check_pass(3, base);

        // N=MAX_N is accepted; check its first element then abort in WRITE
        for (int i = 0; i < MAX_N; i++)
            for (int j = 0; j < MAX_N; j++) begin
                A[i][j] = 64'(i + j + 1);
                B[i][j] = 64'(i * 2 + j + 3);
            end
        base = wr_data.size();
        kick(MAX_N, s);
        chk("nmax_busy", busy, 1);
        w = 0;
        while (!c_wr_en && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("nmax_first_wr_cycle", cyc - s, MAX_N + LAT + 1);
        chk("nmax_c00", c_data, ref_c(MAX_N, 0, 0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("nmax_abort_idle", busy, 0);
        quiet_window(5, "nmax");
        chk("rd_pair", pair_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
